alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/alu_rr_arbiter.sv | 31 +++
 rtl/alu_op_scheduler.sv | 138 +++++++++++++
 tb/tb_alu_op_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Opcodes, FSM encoding and result mapping for alu_op_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_CMP = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] data;
        logic [2:0] flags;
    } rsp_t;

    // Selects which external ALU output becomes the response for an opcode.
    function automatic rsp_t map_result(
        input logic [1:0] op,
        input logic [4:0] sum,
        input logic       gt,
        input logic       eq,
        input logic       lt,
        input logic [3:0] and_v
    );
        rsp_t r;
        r.data  = 5'd0;
        r.flags = 3'd0;
        case (op)
            OP_ADD, OP_SUB: r.data  = sum;
            OP_CMP:         r.flags = {gt, eq, lt};
            default:        r.data  = {1'b0, and_v};
        endcase
        return r;
    endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Brief    : Two-requester round-robin arbiter, one-hot grant, pointer moves
//            only on the update strobe.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    // High when requester 1 wins a tie.
    logic r_prio1;

    assign grant[0] = valid[0] & (~valid[1] | ~r_prio1);
    assign grant[1] = valid[1] & (~valid[0] |  r_prio1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (update) begin
            r_prio1 <= grant[0];
        end
    end

endmodule : alu_rr_arbiter
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler
// Brief    : Arbitrates two requesters onto an external ALU, holds operands for
//            SETTLE_CYCLES cycles, then returns the captured result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_sum,
    input  logic       alu_eq,
    input  logic       alu_gt,
    input  logic       alu_lt,
    input  logic [3:0] alu_and,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [4:0] rsp_data,
    output logic [2:0] rsp_flags
);

    import alu_ctrl_pkg::*;

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_op;
    logic       r_id;

    logic [1:0] w_valid;
    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic       w_accept;
    logic       w_sel_id;
    logic [1:0] w_sel_op;
    logic [3:0] w_sel_a;
    logic [3:0] w_sel_b;
    rsp_t       w_result;

    assign w_valid = {req1_valid, req0_valid};

    alu_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (w_valid),
        .update (w_accept),
        .grant  (w_grant)
    );

    // Readies are gated by rst_n so they drop the instant reset asserts.
    assign w_ready    = w_grant & {2{(r_state == ST_IDLE) & rst_n}};
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign w_accept   = |(w_ready & w_valid);

    assign w_sel_id = w_grant[1];
    assign w_sel_op = w_sel_id ? req1_op : req0_op;
    assign w_sel_a  = w_sel_id ? req1_a  : req0_a;
    assign w_sel_b  = w_sel_id ? req1_b  : req0_b;

    assign w_result = map_result(r_op, alu_sum, alu_gt, alu_eq, alu_lt, alu_and);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_op      <= 2'd0;
            r_id      <= 1'b0;
            alu_s0    <= 1'b0;
            alu_s1    <= 1'b0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 5'd0;
            rsp_flags <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_sel_op;
                        r_id    <= w_sel_id;
                        alu_s1  <= w_sel_op[1];
                        alu_s0  <= w_sel_op[0];
                        alu_a   <= w_sel_a;
                        alu_b   <= w_sel_b;
                        r_cnt   <= c_settle_load;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_data  <= w_result.data;
                        rsp_flags <= w_result.flags;
                        alu_s0    <= 1'b0;
                        alu_s1    <= 1'b0;
                        alu_a     <= 4'd0;
                        alu_b     <= 4'd0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_op_scheduler
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_scheduler
// Brief    : Directed plus random bench for alu_op_scheduler with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;

    localparam int SETTLE = 1;
    localparam int PERIOD = SETTLE + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       alu_s0, alu_s1;
    logic [3:0] alu_a, alu_b;
    logic [4:0] alu_sum;
    logic       alu_eq, alu_gt, alu_lt;
    logic [3:0] alu_and;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [4:0] rsp_data;
    logic [2:0] rsp_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int prio  = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sum(alu_sum), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .alu_and(alu_and),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    // External ALU: subtract only on select 01, otherwise the adder output.
    always_comb begin
        if ({alu_s1, alu_s0} == 2'b01)
            alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        else
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_eq  = (alu_a == alu_b);
        alu_gt  = (alu_a >  alu_b);
        alu_lt  = (alu_a <  alu_b);
        alu_and = alu_a & alu_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {data, flags} from the opcode's arithmetic meaning.
    function automatic logic [7:0] ref_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai = int'(a);
        int bi = int'(b);
        int d  = 0;
        logic [2:0] f = 3'b000;
        case (op)
            2'd0:    d = ai + bi;
            2'd1:    d = (ai + 16 - bi) % 32;
            2'd2:    f = {ai > bi, ai == bi, ai < bi};
            default: d = ai & bi;
        endcase
        return {5'(d), f};
    endfunction

    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) return prio;
        if (v1) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({req1_ready, req0_ready, alu_s1, alu_s0, alu_a, alu_b,
                    rsp_valid, rsp_id, rsp_data, rsp_flags});
    endfunction

    // One transaction from IDLE through response handshake; entered at posedge+1.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [1:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [1:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                          input int stall);
        int g;
        logic [1:0] op;
        logic [3:0] a, b;
        logic [7:0] r;
        rsp_ready  = 1'b0;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        g  = exp_grant(v0, v1);
        op = (g == 1) ? op1 : op0;
        a  = (g == 1) ? a1  : a0;
        b  = (g == 1) ? b1  : b0;
        check("grant", 32'({req1_ready, req0_ready}), (g == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        prio = 1 - g;
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            check("exec_sel", 32'({alu_s1, alu_s0}), 32'(op));
            check("exec_ab", 32'({alu_a, alu_b}), 32'({a, b}));
            check("exec_quiet", 32'({req1_ready, req0_ready, rsp_valid}), 32'd0);
            @(posedge clk);
            #1;
        end
        r = ref_rsp(op, a, b);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_data", 32'(rsp_data), 32'(r[7:3]));
        check("rsp_flags", 32'(rsp_flags), 32'(r[2:0]));
        check("resp_alu_zero", 32'({alu_s1, alu_s0, alu_a, alu_b}), 32'd0);
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            check("stall_ready", 32'({req1_ready, req0_ready}), 32'd0);
            @(posedge clk);
            #1;
            check("stall_hold", 32'({rsp_valid, rsp_id, rsp_data, rsp_flags}),
                  32'({1'b1, g[0], r}));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int acc_cnt, last_acc, last_id;
        logic [7:0] r;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = 4'd0; req1_b = 4'd0;
        #2;
        check("reset_outs", all_outs(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(1, 0, 2'd0, 4'd9, 4'd8, 2'd0, 4'd0, 4'd0, 0);
        run_op(0, 1, 2'd0, 4'd0, 4'd0, 2'd1, 4'd3, 4'd5, 0);
        run_op(0, 1, 2'd0, 4'd0, 4'd0, 2'd1, 4'd5, 4'd3, 1);
        run_op(1, 0, 2'd2, 4'd6, 4'd6, 2'd0, 4'd0, 4'd0, 0);
        run_op(0, 1, 2'd0, 4'd0, 4'd0, 2'd3, 4'd12, 4'd10, 0);
        run_op(1, 1, 2'd2, 4'd2, 4'd9, 2'd2, 4'd9, 4'd2, 5);
        run_op(1, 1, 2'd2, 4'd2, 4'd9, 2'd2, 4'd9, 4'd2, 0);

        for (int t = 0; t < 30; t++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            run_op(pat[0], pat[1],
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)));
        end

        // Both requesters streaming, response always taken.
        req0_op = 2'd0; req0_a = 4'd1;  req0_b = 4'd2;
        req1_op = 2'd3; req1_a = 4'd15; req1_b = 4'd5;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        acc_cnt = 0; last_acc = -1; last_id = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            check("never_both", 32'(req0_ready & req1_ready), 32'd0);
            if (rsp_valid) begin
                r = (last_id == 1) ? ref_rsp(req1_op, req1_a, req1_b) : ref_rsp(req0_op, req0_a, req0_b);
                check("stream_rsp", 32'({rsp_id, rsp_data, rsp_flags}), 32'({last_id[0], r}));
            end
            if (req0_ready | req1_ready) begin
                check("stream_grant", 32'({req1_ready, req0_ready}), (prio == 1) ? 32'd2 : 32'd1);
                if (last_acc >= 0) check("stream_period", 32'(c - last_acc), 32'(PERIOD));
                last_id = prio;
                prio = 1 - prio;
                last_acc = c;
                acc_cnt++;
            end
            @(posedge clk);
        end
        check("stream_count", 32'(acc_cnt), 32'((40 + PERIOD - 1) / PERIOD));
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (SETTLE + 3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset while in EXEC.
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'd9; req0_b = 4'd8;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        prio = 0;
        #1;
        check("rst_exec_outs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_exec_norsp", 32'(rsp_valid), 32'd0);
        end

        // Reset while in RESP, after a requester-0 grant.
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 4'd5; req0_b = 4'd3;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check("pre_rst_resp", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        prio = 0;
        #1;
        check("rst_resp_outs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(1, 1, 2'd0, 4'd7, 4'd7, 2'd1, 4'd0, 4'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_op_scheduler
`default_nettype wire
